// File: rtl/lsq_mem_arbiter.sv
// rtl/lsq_mem_arbiter.sv - load/store queue arbiter onto the single data-cache port
// Optional feature macro: LSQ_MEM_ARB_PERF_EN (adds saturating perf counters)
module lsq_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [MASK_W-1:0] load_rmask,
  output logic              load_ack,
  output logic [DATA_W-1:0] load_rdata,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [MASK_W-1:0] store_wmask,
  input  logic [DATA_W-1:0] store_wdata,
  output logic              store_ack,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [MASK_W-1:0] dmem_rmask,
  output logic [MASK_W-1:0] dmem_wmask,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic              busy
`ifdef LSQ_MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_load_cnt,
  output logic [31:0]       perf_store_cnt,
  output logic [15:0]       perf_drop_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, LOAD_REQ, LOAD_WAIT, STORE_REQ, STORE_WAIT, DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_store;
  logic [ADDR_W-1:0] addr_q;
  logic [MASK_W-1:0] rmask_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] wdata_q;

  logic load_elig, store_elig;
  logic grant_load, grant_store;
  logic load_done, store_done, resp_drop;

  // A requester whose ack is high this cycle is stale and must not be re-granted.
  assign load_elig  = load_req  && !load_ack;
  assign store_elig = store_req && !store_ack;

  // Cache port is driven from latched registers; masks only in the request cycle.
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_rmask = (state_q == LOAD_REQ)  ? rmask_q : '0;
  assign dmem_wmask = (state_q == STORE_REQ) ? wmask_q : '0;
  assign busy       = (state_q != IDLE);

  // Next-state logic: round-robin grant in IDLE, response and flush handling elsewhere.
  always_comb begin
    state_d     = state_q;
    grant_load  = 1'b0;
    grant_store = 1'b0;
    load_done   = 1'b0;
    store_done  = 1'b0;
    resp_drop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          if (load_elig && store_elig) begin
            if (last_grant_store) grant_load  = 1'b1;
            else                  grant_store = 1'b1;
          end else if (load_elig) begin
            grant_load = 1'b1;
          end else if (store_elig) begin
            grant_store = 1'b1;
          end
          if (grant_load)  state_d = LOAD_REQ;
          if (grant_store) state_d = STORE_REQ;
        end
      end
      LOAD_REQ, LOAD_WAIT: begin
        if (dmem_resp) begin
          state_d = IDLE;
          if (flush) resp_drop = 1'b1;
          else       load_done = 1'b1;
        end else if (flush) begin
          state_d = DRAIN;
        end else begin
          state_d = LOAD_WAIT;
        end
      end
      STORE_REQ, STORE_WAIT: begin
        if (dmem_resp) begin
          state_d    = IDLE;
          store_done = 1'b1;
        end else begin
          state_d = STORE_WAIT;
        end
      end
      DRAIN: begin
        if (dmem_resp) begin
          state_d   = IDLE;
          resp_drop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request fields, registered acks and load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      last_grant_store <= 1'b0;
      addr_q           <= '0;
      rmask_q          <= '0;
      wmask_q          <= '0;
      wdata_q          <= '0;
      load_ack         <= 1'b0;
      store_ack        <= 1'b0;
      load_rdata       <= '0;
    end else begin
      state_q   <= state_d;
      load_ack  <= load_done;
      store_ack <= store_done;
      if (load_done) load_rdata <= dmem_rdata;
      if (grant_load) begin
        addr_q           <= load_addr;
        rmask_q          <= load_rmask;
        wmask_q          <= '0;
        last_grant_store <= 1'b0;
      end else if (grant_store) begin
        addr_q           <= store_addr;
        rmask_q          <= '0;
        wmask_q          <= store_wmask;
        wdata_q          <= store_wdata;
        last_grant_store <= 1'b1;
      end
    end
  end

`ifdef LSQ_MEM_ARB_PERF_EN
  // Saturating completion/drop counters; flush never clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_load_cnt  <= '0;
      perf_store_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (load_done && (perf_load_cnt != '1))   perf_load_cnt  <= perf_load_cnt + 32'd1;
      if (store_done && (perf_store_cnt != '1)) perf_store_cnt <= perf_store_cnt + 32'd1;
      if (resp_drop && (perf_drop_cnt != '1))   perf_drop_cnt  <= perf_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// tb/tb_lsq_mem_arbiter.sv - directed self-checking bench for lsq_mem_arbiter
module tb_lsq_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        load_req;
  logic [31:0] load_addr;
  logic [3:0]  load_rmask;
  logic        load_ack;
  logic [31:0] load_rdata;
  logic        store_req;
  logic [31:0] store_addr;
  logic [3:0]  store_wmask;
  logic [31:0] store_wdata;
  logic        store_ack;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        busy;
`ifdef LSQ_MEM_ARB_PERF_EN
  logic [31:0] perf_load_cnt;
  logic [31:0] perf_store_cnt;
  logic [15:0] perf_drop_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  lsq_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_rmask  (load_rmask),
    .load_ack    (load_ack),
    .load_rdata  (load_rdata),
    .store_req   (store_req),
    .store_addr  (store_addr),
    .store_wmask (store_wmask),
    .store_wdata (store_wdata),
    .store_ack   (store_ack),
    .dmem_addr   (dmem_addr),
    .dmem_rmask  (dmem_rmask),
    .dmem_wmask  (dmem_wmask),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_resp   (dmem_resp),
    .busy        (busy)
`ifdef LSQ_MEM_ARB_PERF_EN
    ,
    .perf_load_cnt  (perf_load_cnt),
    .perf_store_cnt (perf_store_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction from IDLE; returns in the cycle after the response.
  task automatic do_txn(input bit is_store, input logic [31:0] a, input logic [31:0] d, input bit fl);
    if (is_store) begin
      store_req = 1'b1; store_addr = a; store_wdata = d; store_wmask = 4'hF;
    end else begin
      load_req = 1'b1; load_addr = a; load_rmask = 4'hF;
    end
    step();
    load_req = 1'b0; store_req = 1'b0;
    step();
    if (fl) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    dmem_resp = 1'b1; dmem_rdata = d;
    step();
    dmem_resp = 1'b0;
    check("txn_load_ack", {31'd0, load_ack}, {31'd0, !is_store && !fl});
    check("txn_store_ack", {31'd0, store_ack}, {31'd0, is_store});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    load_req = 1'b0; load_addr = '0; load_rmask = '0;
    store_req = 1'b0; store_addr = '0; store_wmask = '0; store_wdata = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    step(); step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_load_ack", {31'd0, load_ack}, 32'd0);
    check("rst_store_ack", {31'd0, store_ack}, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
    rst = 1'b0;

    // Single load, cache answers one cycle after the request.
    load_req = 1'b1; load_addr = 32'h0000_1000; load_rmask = 4'hF;
    check("ld_grant_busy", {31'd0, busy}, 32'd0);
    step();
    check("ld_req_rmask", {28'd0, dmem_rmask}, 32'hF);
    check("ld_req_addr", dmem_addr, 32'h0000_1000);
    check("ld_req_wmask", {28'd0, dmem_wmask}, 32'h0);
    check("ld_req_busy", {31'd0, busy}, 32'd1);
    step();
    check("ld_wait_rmask", {28'd0, dmem_rmask}, 32'h0);
    check("ld_wait_busy", {31'd0, busy}, 32'd1);
    check("ld_wait_ack", {31'd0, load_ack}, 32'd0);
    dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_resp = 1'b0;
    check("ld_ack", {31'd0, load_ack}, 32'd1);
    check("ld_rdata", load_rdata, 32'hDEAD_BEEF);
    check("ld_ack_busy", {31'd0, busy}, 32'd0);
    step();
    load_req = 1'b0;
    check("ld_stale_no_grant", {31'd0, busy}, 32'd0);
    check("ld_ack_once", {31'd0, load_ack}, 32'd0);
    check("ld_rdata_hold", load_rdata, 32'hDEAD_BEEF);

    // Round-robin with both requests held continuously after a fresh reset.
    rst = 1'b1; step(); rst = 1'b0;
    load_req = 1'b1; load_addr = 32'h100; load_rmask = 4'hF;
    store_req = 1'b1; store_addr = 32'h200; store_wmask = 4'hF; store_wdata = 32'hCAFE_0000;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        check("rr_store_addr", dmem_addr, 32'h200);
        check("rr_store_wmask", {28'd0, dmem_wmask}, 32'hF);
        check("rr_store_rmask", {28'd0, dmem_rmask}, 32'h0);
        check("rr_store_wdata", dmem_wdata, 32'hCAFE_0000);
      end else begin
        check("rr_load_addr", dmem_addr, 32'h100);
        check("rr_load_rmask", {28'd0, dmem_rmask}, 32'hF);
        check("rr_load_wmask", {28'd0, dmem_wmask}, 32'h0);
      end
      step();
      dmem_resp = 1'b1; dmem_rdata = 32'h0000_0A00 + i;
      step();
      dmem_resp = 1'b0;
      check("rr_store_ack", {31'd0, store_ack}, {31'd0, (i % 2 == 0)});
      check("rr_load_ack", {31'd0, load_ack}, {31'd0, (i % 2 == 1)});
      if (i == 3) begin
        load_req = 1'b0; store_req = 1'b0;
        check("rr_last_rdata", load_rdata, 32'h0000_0A03);
      end
      step();
    end
    check("rr_idle_after", {31'd0, busy}, 32'd0);

    // Flush while a load is waiting; response comes 4 cycles after the flush.
    load_req = 1'b1; load_addr = 32'h300; load_rmask = 4'h3;
    step();
    load_req = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    store_req = 1'b1; store_addr = 32'h400; store_wmask = 4'h3; store_wdata = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      check("drain_busy", {31'd0, busy}, 32'd1);
      check("drain_addr_hold", dmem_addr, 32'h300);
      check("drain_rmask", {28'd0, dmem_rmask}, 32'h0);
      step();
    end
    dmem_resp = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    check("drain_resp_busy", {31'd0, busy}, 32'd1);
    step();
    dmem_resp = 1'b0;
    check("drain_no_ack", {31'd0, load_ack}, 32'd0);
    check("drain_idle", {31'd0, busy}, 32'd0);

    // Store granted after the drain; a flush in STORE_WAIT is ignored.
    step();
    check("st_req_busy", {31'd0, busy}, 32'd1);
    check("st_req_wmask", {28'd0, dmem_wmask}, 32'h3);
    check("st_req_wdata", dmem_wdata, 32'h1234_5678);
    check("st_req_addr", dmem_addr, 32'h400);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("st_flush_busy", {31'd0, busy}, 32'd1);
    check("st_flush_wdata", dmem_wdata, 32'h1234_5678);
    check("st_flush_wmask", {28'd0, dmem_wmask}, 32'h0);
    dmem_resp = 1'b1;
    step();
    dmem_resp = 1'b0;
    check("st_ack", {31'd0, store_ack}, 32'd1);
    check("st_no_load_ack", {31'd0, load_ack}, 32'd0);
    store_req = 1'b0;
    step();
    check("st_ack_once", {31'd0, store_ack}, 32'd0);
    check("st_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in LOAD_WAIT aborts the access.
    load_req = 1'b1; load_addr = 32'h500; load_rmask = 4'hF;
    step();
    step();
    check("arst_pre_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_addr", dmem_addr, 32'd0);
    check("arst_rdata", load_rdata, 32'd0);
    check("arst_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
    step();
    rst = 1'b0;
    check("arst_no_ack", {31'd0, load_ack}, 32'd0);
    step();
    load_req = 1'b0;
    check("arst_regrant_addr", dmem_addr, 32'h500);
    check("arst_regrant_rmask", {28'd0, dmem_rmask}, 32'hF);
    step();
    dmem_resp = 1'b1; dmem_rdata = 32'h1111_2222;
    step();
    dmem_resp = 1'b0;
    check("arst_ack", {31'd0, load_ack}, 32'd1);
    check("arst_ack_rdata", load_rdata, 32'h1111_2222);
    step();

`ifdef LSQ_MEM_ARB_PERF_EN
    do_txn(1'b0, 32'h600, 32'h6, 1'b0);
    step();
    do_txn(1'b1, 32'h700, 32'h7, 1'b0);
    step();
    do_txn(1'b0, 32'h800, 32'h8, 1'b0);
    step();
    do_txn(1'b1, 32'h900, 32'h9, 1'b0);
    step();
    do_txn(1'b0, 32'hA00, 32'hA, 1'b1);
    step();
    check("perf_load", perf_load_cnt, 32'd3);
    check("perf_store", perf_store_cnt, 32'd2);
    check("perf_drop", {16'd0, perf_drop_cnt}, 32'd1);
`else
    do_txn(1'b1, 32'h700, 32'h7, 1'b0);
    step();
    do_txn(1'b0, 32'hA00, 32'hA, 1'b1);
    step();
`endif
    check("end_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
